// File: rtl/miner_pkg.sv
// Shared types and sizing helpers for the multicore miner controller.
package miner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_TGT = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_EVAL     = 3'd4,
        ST_ADVANCE  = 3'd5,
        ST_FOUND    = 3'd6,
        ST_ERR      = 3'd7
    } miner_state_t;

    // A single core still needs a one-bit index so port widths never collapse to zero.
    function automatic int core_idx_w(input int n_cores);
        return (n_cores > 1) ? $clog2(n_cores) : 1;
    endfunction

    localparam int CORE_IDX_W = core_idx_w(4);

endpackage

// File: rtl/miner_ctrl_multicore_nonce_sequencer.sv
// Batch base register: clears, steps by N_CORES with carry-out, and forms base+index for the winner.
module nonce_sequencer #(
    parameter int N_CORES = 4,
    parameter int NONCE_W = 32,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_zero_i,
    input  logic               advance_i,
    input  logic [IDX_W-1:0]   win_idx_i,
    output logic [NONCE_W-1:0] base_o,
    output logic               carry_o,
    output logic [NONCE_W-1:0] winner_o
);

    logic [NONCE_W-1:0] base_q;
    logic [NONCE_W-1:0] base_d;
    logic [NONCE_W:0]   sum_s;

    // Step and winner arithmetic plus base next-state.
    always_comb begin
        sum_s    = {1'b0, base_q} + (NONCE_W+1)'(N_CORES);
        carry_o  = sum_s[NONCE_W];
        winner_o = base_q + NONCE_W'(win_idx_i);
        if (load_zero_i) begin
            base_d = '0;
        end else if (advance_i) begin
            base_d = sum_s[NONCE_W-1:0];
        end else begin
            base_d = base_q;
        end
    end

    // Base register; the wrap on carry-out lands on zero because the base stays N_CORES-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    assign base_o = base_q;

endmodule

// File: rtl/miner_ctrl_multicore.sv
// Lockstep batch scheduler for N_CORES SHA cores: issue, collect done/hit, pick lowest winner, advance.
module miner_ctrl_multicore
    import miner_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int NONCE_W     = 32,
    parameter int TIMEOUT_CYC = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_target,
    input  logic               new_msg,
    input  logic               abort,
    input  logic [N_CORES-1:0] core_done,
    input  logic [N_CORES-1:0] core_hit,
    output logic               begin_sha,
    output logic [NONCE_W-1:0] nonce_base,
    output logic               btc_found,
    output logic [NONCE_W-1:0] winning_nonce,
    output logic               busy,
    output logic               exhausted,
    output logic               timeout_err
);

    localparam int                 IDX_W     = core_idx_w(N_CORES);
    localparam int                 WDOG_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [N_CORES-1:0] ALL_DONE  = '1;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CORES-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            idx = mask[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    miner_state_t       state_q, state_d;
    logic [N_CORES-1:0] done_mask_q, done_mask_d;
    logic [N_CORES-1:0] hit_mask_q, hit_mask_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               resume_q, resume_d;
    logic               msg_pending_q, msg_pending_d;
    logic               exhausted_q, exhausted_d;
    logic               timeout_err_q, timeout_err_d;
    logic [NONCE_W-1:0] winning_nonce_q, winning_nonce_d;
    logic               begin_sha_q, begin_sha_d;
    logic               btc_found_q, btc_found_d;
    logic               busy_q, busy_d;
    logic               busy_now_s;
    logic               all_done_s;
    logic               seq_load_zero_s;
    logic               seq_advance_s;
    logic               seq_carry_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [NONCE_W-1:0] seq_winner_s;

    assign busy_now_s = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                        (state_q == ST_EVAL)  || (state_q == ST_ADVANCE);
    assign all_done_s = ((done_mask_q | core_done) == ALL_DONE);
    assign win_idx_s  = lowest_set(hit_mask_q);

    nonce_sequencer #(
        .N_CORES (N_CORES),
        .NONCE_W (NONCE_W),
        .IDX_W   (IDX_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .load_zero_i (seq_load_zero_s),
        .advance_i   (seq_advance_s),
        .win_idx_i   (win_idx_s),
        .base_o      (nonce_base),
        .carry_o     (seq_carry_s),
        .winner_o    (seq_winner_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: host overrides first (abort > new_target > new_msg), then per-state flow.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (new_target) begin
            state_d = ST_LOAD_TGT;
        end else if (new_msg) begin
            state_d = ST_ISSUE;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_IDLE;
                ST_ERR:      state_d = ST_ERR;
                ST_LOAD_TGT: state_d = (msg_pending_q || resume_q) ? ST_ISSUE : ST_IDLE;
                ST_ISSUE:    state_d = ST_WAIT;
                ST_WAIT: begin
                    if (all_done_s) begin
                        state_d = ST_EVAL;
                    end else if (wdog_q == WDOG_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_EVAL:     state_d = (hit_mask_q != '0) ? ST_FOUND : ST_ADVANCE;
                ST_ADVANCE:  state_d = seq_carry_s ? ST_ERR : ST_ISSUE;
                ST_FOUND:    state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values; masks and watchdog fall back to zero outside WAIT.
    always_comb begin
        done_mask_d     = '0;
        hit_mask_d      = '0;
        wdog_d          = '0;
        resume_d        = resume_q;
        msg_pending_d   = msg_pending_q;
        exhausted_d     = exhausted_q;
        timeout_err_d   = timeout_err_q;
        winning_nonce_d = winning_nonce_q;
        seq_load_zero_s = 1'b0;
        seq_advance_s   = 1'b0;
        if (abort) begin
            resume_d      = 1'b0;
            msg_pending_d = 1'b0;
        end else if (new_target) begin
            resume_d = resume_q | busy_now_s;
            if (new_msg) begin
                msg_pending_d   = 1'b1;
                seq_load_zero_s = 1'b1;
                exhausted_d     = 1'b0;
                timeout_err_d   = 1'b0;
                winning_nonce_d = '0;
            end else begin
                msg_pending_d = msg_pending_q;
            end
        end else if (new_msg) begin
            resume_d        = 1'b0;
            msg_pending_d   = 1'b0;
            seq_load_zero_s = 1'b1;
            exhausted_d     = 1'b0;
            timeout_err_d   = 1'b0;
            winning_nonce_d = '0;
        end else begin
            case (state_q)
                ST_LOAD_TGT: begin
                    resume_d      = 1'b0;
                    msg_pending_d = 1'b0;
                end
                ST_WAIT: begin
                    // A repeat done from a core already counted must not add a late hit.
                    done_mask_d   = done_mask_q | core_done;
                    hit_mask_d    = hit_mask_q | (core_done & ~done_mask_q & core_hit);
                    wdog_d        = wdog_q + WDOG_W'(1);
                    timeout_err_d = timeout_err_q | (~all_done_s & (wdog_q == WDOG_LAST));
                end
                ST_EVAL: begin
                    winning_nonce_d = (hit_mask_q != '0) ? seq_winner_s : winning_nonce_q;
                end
                ST_ADVANCE: begin
                    seq_advance_s = 1'b1;
                    exhausted_d   = exhausted_q | seq_carry_s;
                end
                default: begin
                    resume_d = resume_q;
                end
            endcase
        end
        begin_sha_d = (state_d == ST_ISSUE);
        btc_found_d = (state_d == ST_FOUND);
        busy_d      = (state_d == ST_ISSUE) || (state_d == ST_WAIT) ||
                      (state_d == ST_EVAL)  || (state_d == ST_ADVANCE);
    end

    // Datapath and registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_mask_q     <= '0;
            hit_mask_q      <= '0;
            wdog_q          <= '0;
            resume_q        <= 1'b0;
            msg_pending_q   <= 1'b0;
            exhausted_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
            winning_nonce_q <= '0;
            begin_sha_q     <= 1'b0;
            btc_found_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            done_mask_q     <= done_mask_d;
            hit_mask_q      <= hit_mask_d;
            wdog_q          <= wdog_d;
            resume_q        <= resume_d;
            msg_pending_q   <= msg_pending_d;
            exhausted_q     <= exhausted_d;
            timeout_err_q   <= timeout_err_d;
            winning_nonce_q <= winning_nonce_d;
            begin_sha_q     <= begin_sha_d;
            btc_found_q     <= btc_found_d;
            busy_q          <= busy_d;
        end
    end

    assign begin_sha     = begin_sha_q;
    assign btc_found     = btc_found_q;
    assign busy          = busy_q;
    assign exhausted     = exhausted_q;
    assign timeout_err   = timeout_err_q;
    assign winning_nonce = winning_nonce_q;

endmodule

// File: tb/tb_miner_ctrl_multicore.sv
// Randomized bench for miner_ctrl_multicore with a batch-level reference model.
module tb_miner_ctrl_multicore;

    localparam int NC    = 4;
    localparam int NW    = 5;
    localparam int TO    = 8;
    localparam int SPACE = 1 << NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          new_target;
    logic          new_msg;
    logic          abort;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_hit;
    logic          begin_sha;
    logic [NW-1:0] nonce_base;
    logic          btc_found;
    logic [NW-1:0] winning_nonce;
    logic          busy;
    logic          exhausted;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    miner_ctrl_multicore #(
        .N_CORES     (NC),
        .NONCE_W     (NW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .new_target    (new_target),
        .new_msg       (new_msg),
        .abort         (abort),
        .core_done     (core_done),
        .core_hit      (core_hit),
        .begin_sha     (begin_sha),
        .nonce_base    (nonce_base),
        .btc_found     (btc_found),
        .winning_nonce (winning_nonce),
        .busy          (busy),
        .exhausted     (exhausted),
        .timeout_err   (timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_msg();
        new_msg = 1'b1;
        tick();
        new_msg = 1'b0;
    endtask

    function automatic int lowest_hit(input logic [NC-1:0] h);
        for (int i = 0; i < NC; i++) begin
            if (h[i]) return i;
        end
        return -1;
    endfunction

    task automatic gen_batch(output logic [NC-1:0] hits, output int dly[NC]);
        for (int i = 0; i < NC; i++) begin
            hits[i] = ($urandom_range(0, 5) == 0);
            dly[i]  = $urandom_range(1, TO);
        end
    endtask

    // Entered at the sample point of the ISSUE cycle. dly[i]=0 means core i never answers.
    // outcome: 0 advance, 1 found, 2 timeout, 3 exhausted.
    task automatic run_batch(input int exp_base, input logic [NC-1:0] hits, input int dly[NC],
                             input bit noise, output int outcome);
        int  last;
        bit  never;
        int  lim;
        last  = 0;
        never = 1'b0;
        check_eq("begin_sha", {31'd0, begin_sha}, 32'd1);
        check_eq("nonce_base", {27'd0, nonce_base}, exp_base);
        for (int i = 0; i < NC; i++) begin
            if (dly[i] == 0) never = 1'b1;
            else if (dly[i] > last) last = dly[i];
        end
        if (noise) begin
            core_done = NC'($urandom);
            core_hit  = NC'($urandom);
        end
        tick();
        lim = never ? TO : last;
        for (int n = 1; n <= lim; n++) begin
            core_done = '0;
            core_hit  = '0;
            for (int i = 0; i < NC; i++) begin
                if (dly[i] == n) begin
                    core_done[i] = 1'b1;
                    core_hit[i]  = hits[i];
                end else if (noise && dly[i] != 0 && dly[i] < n && $urandom_range(0, 2) == 0) begin
                    core_done[i] = 1'b1;
                    core_hit[i]  = 1'b1;
                end
            end
            if (n == 1) check_eq("busy_wait", {31'd0, busy}, 32'd1);
            if (never && n == TO) check_eq("timeout_pre", {31'd0, timeout_err}, 32'd0);
            tick();
        end
        core_done = '0;
        core_hit  = '0;
        if (never) begin
            check_eq("timeout_err", {31'd0, timeout_err}, 32'd1);
            check_eq("busy_tmo", {31'd0, busy}, 32'd0);
            outcome = 2;
        end else if (hits != '0) begin
            check_eq("btc_early", {31'd0, btc_found}, 32'd0);
            tick();
            check_eq("btc_found", {31'd0, btc_found}, 32'd1);
            check_eq("winning_nonce", {27'd0, winning_nonce}, exp_base + lowest_hit(hits));
            outcome = 1;
        end else begin
            tick();
            tick();
            if (exp_base + NC >= SPACE) begin
                check_eq("exhausted", {31'd0, exhausted}, 32'd1);
                check_eq("busy_exh", {31'd0, busy}, 32'd0);
                check_eq("base_wrap", {27'd0, nonce_base}, 32'd0);
                check_eq("issue_exh", {31'd0, begin_sha}, 32'd0);
                outcome = 3;
            end else begin
                outcome = 0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            o;
        int            d[NC];
        logic [NC-1:0] h;
        int            base;

        rst        = 1'b1;
        new_target = 1'b0;
        new_msg    = 1'b0;
        abort      = 1'b0;
        core_done  = '0;
        core_hit   = '0;
        tick();
        tick();
        check_eq("rst_begin", {31'd0, begin_sha}, 32'd0);
        check_eq("rst_btc", {31'd0, btc_found}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_exh", {31'd0, exhausted}, 32'd0);
        check_eq("rst_tmo", {31'd0, timeout_err}, 32'd0);
        check_eq("rst_base", {27'd0, nonce_base}, 32'd0);
        check_eq("rst_win", {27'd0, winning_nonce}, 32'd0);
        rst = 1'b0;
        tick();

        // Staggered completion with a single hit on core 2 at base 8.
        pulse_msg();
        gen_batch(h, d);
        run_batch(0, '0, d, 1'b1, o);
        gen_batch(h, d);
        run_batch(4, '0, d, 1'b1, o);
        d[0] = 3; d[1] = 4; d[2] = 5; d[3] = 5;
        run_batch(8, 4'b0100, d, 1'b0, o);
        check_eq("t1_outcome", o, 32'd1);
        tick();
        check_eq("btc_single", {31'd0, btc_found}, 32'd0);

        // Two hits pick the lowest index; then abort in WAIT.
        pulse_msg();
        check_eq("win_cleared", {27'd0, winning_nonce}, 32'd0);
        gen_batch(h, d);
        run_batch(0, 4'b1010, d, 1'b1, o);
        tick();
        pulse_msg();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_issue", {31'd0, begin_sha}, 32'd0);

        // Full nonce space without a hit.
        pulse_msg();
        for (int b = 0; b < SPACE / NC; b++) begin
            gen_batch(h, d);
            run_batch(b * NC, '0, d, 1'b1, o);
        end
        check_eq("t2_outcome", o, 32'd3);
        tick();
        check_eq("err_idle", {31'd0, begin_sha}, 32'd0);
        check_eq("exh_sticky", {31'd0, exhausted}, 32'd1);

        // Core 3 never answers: watchdog, then new_msg clears the flag.
        pulse_msg();
        check_eq("exh_clear", {31'd0, exhausted}, 32'd0);
        d[0] = 2; d[1] = 3; d[2] = 1; d[3] = 0;
        run_batch(0, '0, d, 1'b0, o);
        tick();
        check_eq("tmo_sticky", {31'd0, timeout_err}, 32'd1);
        check_eq("tmo_noissue", {31'd0, begin_sha}, 32'd0);
        pulse_msg();
        check_eq("tmo_clear", {31'd0, timeout_err}, 32'd0);

        // Target reload mid-WAIT at base 20 re-issues the same batch with fresh masks.
        for (int b = 0; b < 5; b++) begin
            gen_batch(h, d);
            run_batch(b * NC, '0, d, 1'b1, o);
        end
        check_eq("t4_base", {27'd0, nonce_base}, 32'd20);
        tick();
        core_done = 4'b0001;
        tick();
        core_done  = '0;
        new_target = 1'b1;
        tick();
        new_target = 1'b0;
        check_eq("ldt_busy", {31'd0, busy}, 32'd0);
        check_eq("ldt_issue", {31'd0, begin_sha}, 32'd0);
        tick();
        d[0] = 4; d[1] = 1; d[2] = 1; d[3] = 1;
        run_batch(20, 4'b0001, d, 1'b0, o);
        tick();

        // Target reload while idle returns to idle without issuing.
        new_target = 1'b1;
        tick();
        new_target = 1'b0;
        check_eq("ldt_idle_issue", {31'd0, begin_sha}, 32'd0);
        tick();
        check_eq("ldt_idle_stay", {31'd0, begin_sha}, 32'd0);
        check_eq("ldt_idle_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-WAIT, then simultaneous new_target and new_msg.
        pulse_msg();
        gen_batch(h, d);
        run_batch(0, '0, d, 1'b1, o);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_base", {27'd0, nonce_base}, 32'd0);
        check_eq("arst_begin", {31'd0, begin_sha}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        new_target = 1'b1;
        new_msg    = 1'b1;
        tick();
        new_target = 1'b0;
        new_msg    = 1'b0;
        check_eq("both_ldt", {31'd0, begin_sha}, 32'd0);
        tick();
        gen_batch(h, d);
        run_batch(0, 4'b1000, d, 1'b1, o);

        // Randomized searches until a hit or exhaustion.
        for (int r = 0; r < 6; r++) begin
            tick();
            pulse_msg();
            base = 0;
            o    = 0;
            while (o == 0) begin
                gen_batch(h, d);
                run_batch(base, h, d, 1'b1, o);
                base += NC;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
